// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address helpers for the instruction cache.
//   state_e   - refill FSM states
//   RESET_NOP - instruction presented to fetch while stalled (addi x0,x0,0)
//   get_off / get_idx / get_tag - split a byte address into word offset,
//   set index and tag, given the offset and index field widths in bits.
package icache_pkg;

  typedef enum logic {
    IDLE,
    REFILL
  } state_e;

  localparam logic [31:0] RESET_NOP = 32'h0000_0013;

  function automatic logic [31:0] field_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // word offset = a[off_w+1:2]
  function automatic logic [31:0] get_off(input logic [31:0] a, input int off_w);
    return (a >> 2) & field_mask(off_w);
  endfunction

  // index = a[off_w+idx_w+1:off_w+2]
  function automatic logic [31:0] get_idx(input logic [31:0] a, input int off_w, input int idx_w);
    return (a >> (off_w + 2)) & field_mask(idx_w);
  endfunction

  // tag = a[31:off_w+idx_w+2]
  function automatic logic [31:0] get_tag(input logic [31:0] a, input int off_w, input int idx_w);
    return a >> (off_w + idx_w + 2);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram: SETS x WPL x 32-bit line storage.
//   clk                   - write clock
//   we_i/widx_i/woff_i/wdata_i - synchronous write port (refill path)
//   ridx_i/roff_i/rdata_o - combinational read port (hit path)
// Contents are not reset; the tag/valid array decides what is meaningful.
module icache_data_ram #(
  parameter int SETS = 64,
  parameter int WPL  = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(SETS)-1:0]  widx_i,
  input  logic [$clog2(WPL)-1:0]   woff_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(SETS)-1:0]  ridx_i,
  input  logic [$clog2(WPL)-1:0]   roff_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [SETS][WPL];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i][woff_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i][roff_i];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache.
//   clk, rst         - clock, synchronous active-high reset
//   A, RD, StallF    - fetch lookup: PC in, instruction out, stall when absent
//   flush            - invalidate all lines (fence.i)
//   mem_req/mem_addr - one-beat refill request to backing memory
//   mem_valid/mem_rdata - beat completes when mem_req && mem_valid
// Hits are answered combinationally in IDLE. A miss latches the line base and
// fetches WORDS_PER_LINE beats in order, then returns to IDLE where the same
// PC is looked up again.
module icache #(
  parameter int          SETS           = 64,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] RESET_NOP      = icache_pkg::RESET_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  output logic [31:0] RD,
  output logic        StallF,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata
);
  import icache_pkg::*;

  localparam int OFF = $clog2(WORDS_PER_LINE);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = 32 - OFF - IDX - 2;

  state_e            state_q, state_d;
  logic [OFF-1:0]    beat_q, beat_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic              cancel_q, cancel_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TW-1:0]     tag_q [SETS];

  logic [IDX-1:0]    a_idx, m_idx;
  logic [OFF-1:0]    a_off;
  logic [TW-1:0]     a_tag, m_tag;
  logic              lookup, hit, beat_done, last_beat, fill_we;
  logic [31:0]       ram_rd;

  assign a_idx = IDX'(get_idx(A, OFF, IDX));
  assign a_off = OFF'(get_off(A, OFF));
  assign a_tag = TW'(get_tag(A, OFF, IDX));
  assign m_idx = IDX'(get_idx(miss_addr_q, OFF, IDX));
  assign m_tag = TW'(get_tag(miss_addr_q, OFF, IDX));

  // During reset the outputs behave as in IDLE regardless of the old state,
  // so an in-flight request is dropped in the reset cycle itself.
  assign lookup    = (state_q == IDLE) || rst;
  assign hit       = lookup && valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign beat_done = (state_q == REFILL) && !rst && mem_valid;
  assign last_beat = (beat_q == OFF'(WORDS_PER_LINE - 1));

  assign RD       = hit ? ram_rd : RESET_NOP;
  assign StallF   = !hit;
  assign mem_req  = (state_q == REFILL) && !rst;
  assign mem_addr = {miss_addr_q[31:OFF+2], beat_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    miss_addr_d = miss_addr_q;
    cancel_d    = cancel_q;
    valid_d     = valid_q;
    fill_we     = 1'b0;
    case (state_q)
      IDLE: begin
        // The lookup this cycle already used the pre-flush valid bits.
        if (flush) valid_d = '0;
        if (!hit) begin
          state_d     = REFILL;
          miss_addr_d = {A[31:OFF+2], {(OFF+2){1'b0}}};
          beat_d      = '0;
          cancel_d    = 1'b0;
        end
      end
      REFILL: begin
        if (flush) cancel_d = 1'b1;
        if (beat_done) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            // A flush on the final beat cancels just like an earlier one.
            fill_we  = !(cancel_q || flush);
            state_d  = IDLE;
            cancel_d = 1'b0;
            beat_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fill_we) valid_d[m_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      miss_addr_q <= '0;
      cancel_q    <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      miss_addr_q <= miss_addr_d;
      cancel_q    <= cancel_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) tag_q[m_idx] <= m_tag;
  end

  icache_data_ram #(
    .SETS (SETS),
    .WPL  (WORDS_PER_LINE)
  ) u_data (
    .clk     (clk),
    .we_i    (beat_done),
    .widx_i  (m_idx),
    .woff_i  (beat_q),
    .wdata_i (mem_rdata),
    .ridx_i  (a_idx),
    .roff_i  (a_off),
    .rdata_o (ram_rd)
  );

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed bench for icache with a behavioural backing memory
// returning addr ^ 32'hA5A50000.
module tb_icache;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, flush, mem_valid;
  logic [31:0] A;
  logic [31:0] RD, mem_addr, mem_rdata;
  logic        StallF, mem_req;

  int checks = 0;
  int failures = 0;
  logic [31:0] beats[$];

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ XK;

  icache dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .RD        (RD),
    .StallF    (StallF),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One lookup of addr, run until StallF drops. Returns the stall cycle
  // count, cycles mem_req was up on the line base address, whether mem_req
  // was up in the first cycle, and stalled cycles where RD was not the NOP.
  // Completed beat addresses go to beats[]. Ends at the negedge of the
  // first non-stalled cycle so the caller can inspect RD.
  task automatic run(input logic [31:0] addr, input bit slow, input int flush_at,
                     output int stall, output int hold, output bit req0, output int nop_bad);
    bit done = 0;
    stall = 0; hold = 0; req0 = 0; nop_bad = 0;
    beats.delete();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      rst       = 1'b0;
      A         = addr;
      mem_valid = slow ? (i % 3 == 2) : 1'b1;
      flush     = (i == flush_at);
      @(negedge clk);
      if (i == 0) req0 = mem_req;
      if (!StallF) begin done = 1; break; end
      stall++;
      if (RD !== NOP) nop_bad++;
      if (mem_req && mem_addr == {addr[31:4], 4'h0}) hold++;
      if (mem_req && mem_valid) beats.push_back(mem_addr);
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic fill(input string nm, input logic [31:0] addr);
    int st, hd, np; bit r0;
    run(addr, 1'b0, -1, st, hd, r0, np);
    chk({nm, "_stall"}, st, 5);
    chk({nm, "_nbeats"}, beats.size(), 4);
    for (int k = 0; k < 4 && k < beats.size(); k++)
      chk({nm, "_addr"}, beats[k], {addr[31:4], 4'h0} + 32'(4 * k));
    chk({nm, "_rd"}, RD, addr ^ XK);
    chk({nm, "_nop"}, np, 0);
  endtask

  task automatic hit(input string nm, input logic [31:0] addr);
    int st, hd, np; bit r0;
    run(addr, 1'b0, -1, st, hd, r0, np);
    chk({nm, "_stall"}, st, 0);
    chk({nm, "_rd"}, RD, addr ^ XK);
    chk({nm, "_req"}, mem_req, 0);
  endtask

  initial begin
    int st, hd, np; bit r0;
    rst = 1'b1; flush = 1'b0; mem_valid = 1'b0; A = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", StallF, 1);
    chk("rst_rd", RD, NOP);
    chk("rst_req", mem_req, 0);

    // cold miss, then hits within the line
    fill("cold", 32'h100);
    hit("hit108", 32'h108);
    hit("hit104", 32'h104);

    // conflict eviction: 0x500 shares index with 0x100
    fill("evict500", 32'h500);
    fill("back100", 32'h100);
    hit("hit500gone", 32'h10C);

    // slow memory: valid on every third cycle
    run(32'h200, 1'b1, -1, st, hd, r0, np);
    chk("slow_stall", st, 12);
    chk("slow_hold", hd, 2);
    chk("slow_nbeats", beats.size(), 4);
    if (beats.size() == 4) chk("slow_addr3", beats[3], 32'h20C);
    chk("slow_rd", RD, 32'h200 ^ XK);
    chk("slow_nop", np, 0);
    hit("slow_hit", 32'h208);

    // flush during refill: line not kept, refilled a second time
    run(32'h300, 1'b0, 2, st, hd, r0, np);
    chk("fl_stall", st, 10);
    chk("fl_nbeats", beats.size(), 8);
    chk("fl_rd", RD, 32'h300 ^ XK);
    hit("fl_hit", 32'h304);

    // flush in IDLE: same-cycle lookup hits, next access misses
    run(32'h100, 1'b0, 0, st, hd, r0, np);
    chk("fi_stall", st, 0);
    chk("fi_rd", RD, 32'h100 ^ XK);
    fill("fi_miss", 32'h100);

    // reset after two completed beats of a refill of 0x600
    @(posedge clk); #1;
    A = 32'h600; mem_valid = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mr_req", mem_req, 0);
    chk("mr_stall", StallF, 1);
    chk("mr_rd", RD, NOP);
    run(32'h100, 1'b0, -1, st, hd, r0, np);
    chk("mr_req0", r0, 0);
    chk("mr_stall5", st, 5);
    if (beats.size() > 0) chk("mr_addr0", beats[0], 32'h100);
    else chk("mr_addr0", 32'hFFFF_FFFF, 32'h100);
    chk("mr_rdfill", RD, 32'h100 ^ XK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
